// File: rtl/coffee_pkg.sv
// Shared types and default coin/credit configuration for the coffee-maker vending path.
package coffee_pkg;

    localparam int DEF_CREDIT_W  = 8;
    localparam int DEF_NUM_COINS = 3;
    localparam int DEF_MAX_CREDIT = 99;
    localparam logic [DEF_NUM_COINS*DEF_CREDIT_W-1:0] DEF_COIN_VALUES = {8'd10, 8'd5, 8'd1};

    typedef enum logic {
        IDLE   = 1'b0,
        CHANGE = 1'b1
    } cc_state_e;

endpackage

// File: rtl/coin_change_select.sv
// Greedy change picker: index of the largest denomination not exceeding credit.
module coin_change_select
    import coffee_pkg::*;
#(
    parameter int NUM_COINS = DEF_NUM_COINS,
    parameter int CREDIT_W  = DEF_CREDIT_W,
    parameter logic [NUM_COINS*CREDIT_W-1:0] COIN_VALUES = DEF_COIN_VALUES
) (
    input  logic [CREDIT_W-1:0]          credit,
    output logic [$clog2(NUM_COINS)-1:0] coin_idx
);

    localparam int IDX_W = $clog2(NUM_COINS);

    // Table is ascending, so the last fitting entry wins; entry 0 (value 1) is the fallback.
    always_comb begin
        coin_idx = '0;
        for (int i = 1; i < NUM_COINS; i++) begin
            if (credit >= COIN_VALUES[i*CREDIT_W +: CREDIT_W])
                coin_idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/coin_credit_unit.sv
// Credit accumulator: all-or-nothing coin acceptance, vend check against price,
// and greedy change return over a valid/ready handshake.
module coin_credit_unit
    import coffee_pkg::*;
#(
    parameter int NUM_COINS  = DEF_NUM_COINS,
    parameter int CREDIT_W   = DEF_CREDIT_W,
    parameter logic [NUM_COINS*CREDIT_W-1:0] COIN_VALUES = DEF_COIN_VALUES,
    parameter int MAX_CREDIT = DEF_MAX_CREDIT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_COINS-1:0]         coin,
    input  logic [CREDIT_W-1:0]          price,
    input  logic                         vend_req,
    input  logic                         cancel,
    input  logic                         change_ready,
    output logic [CREDIT_W-1:0]          credit,
    output logic                         coin_reject,
    output logic                         vend_ack,
    output logic                         vend_nack,
    output logic                         change_valid,
    output logic [$clog2(NUM_COINS)-1:0] change_coin,
    output logic                         busy
);

    localparam int IDX_W = $clog2(NUM_COINS);
    localparam int SUM_W = CREDIT_W + IDX_W;

    cc_state_e            state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [IDX_W-1:0]     change_coin_q, change_coin_d;
    logic                 reject_q, reject_d;
    logic                 ack_q, ack_d;
    logic                 nack_q, nack_d;

    logic [SUM_W-1:0]     coin_sum;
    logic [SUM_W:0]       grown;
    logic [CREDIT_W-1:0]  change_val;
    logic [IDX_W-1:0]     sel_idx;

    always_comb begin
        coin_sum = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (coin[i])
                coin_sum = coin_sum + SUM_W'(COIN_VALUES[i*CREDIT_W +: CREDIT_W]);
        end
    end

    // One extra bit so the overflow test never wraps.
    assign grown = {{(IDX_W+1){1'b0}}, credit_q} + {1'b0, coin_sum};

    always_comb begin
        change_val = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (change_coin_q == IDX_W'(i))
                change_val = COIN_VALUES[i*CREDIT_W +: CREDIT_W];
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        ack_d    = 1'b0;
        nack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grown <= (SUM_W+1)'(MAX_CREDIT))
                    credit_d = CREDIT_W'(grown);
                else
                    reject_d = 1'b1;
                // Price is judged against credit held before this cycle's coins.
                if (cancel) begin
                    if (credit_q != '0)
                        state_d = CHANGE;
                end else if (vend_req) begin
                    if (credit_q >= price) begin
                        ack_d    = 1'b1;
                        credit_d = credit_d - price;
                        if (credit_d != '0)
                            state_d = CHANGE;
                    end else begin
                        nack_d = 1'b1;
                    end
                end
            end
            CHANGE: begin
                reject_d = |coin;
                if (change_ready) begin
                    credit_d = credit_q - change_val;
                    if (credit_d == '0)
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    coin_change_select #(
        .NUM_COINS  (NUM_COINS),
        .CREDIT_W   (CREDIT_W),
        .COIN_VALUES(COIN_VALUES)
    ) u_sel (
        .credit  (credit_d),
        .coin_idx(sel_idx)
    );

    // Next offer follows the post-handshake credit, so it is stable while ready is low.
    assign change_coin_d = (state_d == CHANGE) ? sel_idx : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            change_coin_q <= '0;
            reject_q      <= 1'b0;
            ack_q         <= 1'b0;
            nack_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            change_coin_q <= change_coin_d;
            reject_q      <= reject_d;
            ack_q         <= ack_d;
            nack_q        <= nack_d;
        end
    end

    assign credit       = credit_q;
    assign coin_reject  = reject_q;
    assign vend_ack     = ack_q;
    assign vend_nack    = nack_q;
    assign change_valid = (state_q == CHANGE);
    assign change_coin  = change_coin_q;
    assign busy         = (state_q == CHANGE);

endmodule

// File: tb/tb_coin_credit_unit.sv
// Scoreboard bench for coin_credit_unit: a behavioural model queues the expected
// post-edge outputs, a negedge monitor pops and compares them.
module tb_coin_credit_unit;

    logic       clk, reset;
    logic [2:0] coin;
    logic [7:0] price;
    logic       vend_req, cancel, change_ready;
    logic [7:0] credit;
    logic       coin_reject, vend_ack, vend_nack, change_valid, busy;
    logic [1:0] change_coin;

    coin_credit_unit dut (
        .clk(clk), .reset(reset), .coin(coin), .price(price),
        .vend_req(vend_req), .cancel(cancel), .change_ready(change_ready),
        .credit(credit), .coin_reject(coin_reject), .vend_ack(vend_ack),
        .vend_nack(vend_nack), .change_valid(change_valid),
        .change_coin(change_coin), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int credit;
        bit rej, ack, nack, cv, busy;
        int cc;
    } exp_t;

    exp_t sbq[$];
    int   n_pass = 0;
    int   n_total = 0;

    int vals[3] = '{1, 5, 10};
    int m_credit = 0;
    bit m_chg = 0;

    function automatic int largest(input int c);
        for (int i = 2; i >= 0; i--)
            if (vals[i] <= c) return i;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("credit",       int'(credit),       e.credit);
            chk("coin_reject",  int'(coin_reject),  int'(e.rej));
            chk("vend_ack",     int'(vend_ack),     int'(e.ack));
            chk("vend_nack",    int'(vend_nack),    int'(e.nack));
            chk("change_valid", int'(change_valid), int'(e.cv));
            chk("busy",         int'(busy),         int'(e.busy));
            chk("change_coin",  int'(change_coin),  e.cc);
        end
    end

    task automatic step(input logic [2:0] c, input int p, input bit v, input bit x,
                        input bit r, input bit rs);
        exp_t e;
        int   sum, nc;
        @(negedge clk);
        coin = c; price = 8'(p); vend_req = v; cancel = x; change_ready = r; reset = rs;
        e.rej = 0; e.ack = 0; e.nack = 0;
        if (rs) begin
            m_credit = 0;
            m_chg = 0;
        end else if (!m_chg) begin
            sum = 0;
            for (int i = 0; i < 3; i++) if (c[i]) sum += vals[i];
            nc = m_credit;
            if (m_credit + sum <= 99) nc += sum;
            else e.rej = 1;
            if (x) begin
                if (m_credit > 0) m_chg = 1;
            end else if (v) begin
                if (m_credit >= p) begin
                    e.ack = 1;
                    nc -= p;
                    m_chg = (nc > 0);
                end else e.nack = 1;
            end
            m_credit = nc;
        end else begin
            e.rej = (c != 0);
            if (r) begin
                m_credit -= vals[largest(m_credit)];
                if (m_credit == 0) m_chg = 0;
            end
        end
        e.credit = m_credit;
        e.cv = m_chg;
        e.busy = m_chg;
        e.cc = m_chg ? largest(m_credit) : 0;
        @(posedge clk);
        sbq.push_back(e);
    endtask

    task automatic put(input int idx);
        logic [2:0] c;
        c = '0;
        c[idx] = 1'b1;
        step(c, 0, 0, 0, 1, 0);
    endtask

    task automatic idle(input int n, input bit r);
        repeat (n) step(3'b000, 0, 0, 0, r, 0);
    endtask

    task automatic rst();
        step(3'b000, 0, 0, 0, 0, 1);
    endtask

    initial begin
        coin = '0; price = '0; vend_req = 0; cancel = 0; change_ready = 0; reset = 1;
        rst();
        put(0); put(1); put(2);                 // 1, 6, 16
        rst(); repeat (9) put(2); put(1);       // 95
        put(1);                                 // rejected, stays 95
        rst(); repeat (9) put(2); repeat (3) put(0);
        step(3'b011, 0, 0, 0, 1, 0);            // 93 + 6 = 99
        step(3'b001, 0, 0, 0, 1, 0);            // at max: reject
        rst(); put(2); put(1); put(0);
        step(3'b000, 12, 1, 0, 1, 0);           // ack, 4 left, change 1,1,1,1
        idle(6, 1);
        rst(); put(1); put(0); put(0);
        step(3'b010, 12, 1, 0, 1, 0);           // nack, coin still lands -> 12
        step(3'b000, 0, 1, 0, 1, 0);            // price 0 acks
        idle(3, 1);
        rst(); put(2); put(2); put(1); put(0); put(0);
        step(3'b000, 0, 0, 1, 0, 0);            // cancel at 27
        for (int i = 0; i < 12; i++)
            step((i == 3 || i == 6) ? 3'b101 : 3'b000, 0, 0, 0, (i % 2) == 1, 0);
        rst(); put(1); put(0);
        step(3'b000, 0, 0, 1, 0, 0);            // CHANGE at 6
        step(3'b000, 0, 0, 0, 1, 1);            // reset mid-CHANGE
        idle(2, 1);
        rst(); put(2); put(2);
        step(3'b000, 5, 1, 1, 1, 0);            // cancel beats vend
        idle(4, 1);
        rst();
        step(3'b000, 0, 0, 1, 1, 0);            // cancel at zero credit: no-op
        for (int i = 0; i < 800; i++) begin
            logic [2:0] c;
            for (int b = 0; b < 3; b++) c[b] = ($urandom_range(0, 3) == 0);
            step(c, int'($urandom_range(0, 30)), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 199) == 0);
        end
        idle(30, 1);
        @(negedge clk);
        #1;
        n_total++;
        if (sbq.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/coin_credit_unit.md
Name: coin_credit_unit

Overview:
Parametrised credit accumulator for the coffee-maker vending path. It accepts up to NUM_COINS coin denominations per cycle and saturates by rejecting any coin that would push credit past MAX_CREDIT. It checks credit against the selected drink price, and returns change greedily through a valid/ready handshake to the coin-return mechanism. It sits between the coin-slot debouncers and the brew controller FSM.

Parameters:
NUM_COINS, 3, number of coin denominations (coin inputs).
CREDIT_W, 8, width of credit, price and coin values.
COIN_VALUES, {8'd10,8'd5,8'd1}, packed NUM_COINS*CREDIT_W value table; entry i is the value of coin[i]; entry 0 must be 1 and entries must be strictly ascending.
MAX_CREDIT, 99, highest credit the unit will hold.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
coin  in  NUM_COINS  one-cycle pulse per inserted coin; several bits may be set in the same cycle
price  in  CREDIT_W  price of the selected drink, sampled on vend_req
vend_req  in  1  one-cycle request to buy
cancel  in  1  one-cycle request to refund all credit
change_ready  in  1  coin-return mechanism accepts the current change coin
credit  out  CREDIT_W  current credit (registered)
coin_reject  out  1  one-cycle pulse: coin(s) this cycle were not accepted
vend_ack  out  1  one-cycle pulse: vend accepted, price deducted
vend_nack  out  1  one-cycle pulse: vend refused, credit insufficient
change_valid  out  1  a change coin is offered
change_coin  out  $clog2(NUM_COINS)  index of the offered denomination
busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk. All outputs are registered.
- Reset: credit=0, state=IDLE, and all pulses, change_valid, change_coin and busy are 0. Reset mid-CHANGE discards the remaining credit with no further change pulses.
- States: IDLE and CHANGE.
- IDLE coin handling: coin_sum is the sum of COIN_VALUES[i] over the set bits of coin, computed at CREDIT_W+$clog2(NUM_COINS) bits.
  - If credit+coin_sum <= MAX_CREDIT, credit += coin_sum.
  - Otherwise the whole group is rejected: credit is unchanged and coin_reject pulses the next cycle. There is no partial acceptance.
- IDLE vend: vend_req compares price against credit before this cycle's coins.
  - If credit >= price: credit_next = credit + accepted coin_sum - price, and vend_ack pulses.
  - If credit < price: vend_nack pulses and credit takes only the coin update.
  - price=0 always acks.
- Entering CHANGE:
  - After a vend_ack, go to CHANGE if credit_next > 0, otherwise stay in IDLE.
  - cancel in IDLE goes to CHANGE if credit > 0, otherwise it is a no-op.
  - cancel and vend_req in the same cycle: cancel wins and no ack/nack is issued. Coins in that cycle are still accepted.
- CHANGE:
  - change_valid=1. change_coin is the highest index with COIN_VALUES[i] <= credit; it stays stable while change_ready=0.
  - On change_valid && change_ready, credit -= COIN_VALUES[change_coin]. The next coin is recomputed in the following cycle, giving one handshake per cycle at most.
  - When credit reaches 0, change_valid drops and the FSM returns to IDLE in the same update.
  - Any coin input in CHANGE pulses coin_reject; vend_req and cancel are ignored there.
- Latency: a coin is visible on credit one cycle after the pulse; ack/nack/reject appear one cycle after their cause.
- Invariants: credit <= MAX_CREDIT at all times; credit never underflows.

Decomposition:
- A shared package coffee_pkg holds:
  - the state enum (IDLE, CHANGE);
  - default COIN_VALUES;
  - MAX_CREDIT;
  - the credit width.
- One sub-module, coin_change_select: purely combinational greedy selection that takes credit and returns the highest denomination index fitting in it. It is reused by the brew controller display logic.

Test Plan:
- Insert coins 1,5,10 in three cycles -> credit 1, 6, 16; no reject.
- credit=95, coin[1] (5) -> coin_reject pulse, credit stays 95. Then coin[0]+coin[1] in the same cycle at credit 93 -> credit 99.
- credit=16, price=12, vend_req -> vend_ack, credit 4, CHANGE. With change_ready held 1: change_coin 0 four times, credit 3,2,1,0, then IDLE and busy=0.
- credit=7, price=12, vend_req -> vend_nack, credit 7, stays IDLE. Same cycle coin[1] -> credit 12.
- credit=27, cancel with change_ready toggling 1/0 -> change_coin 2,2,1,0,0 (10,10,5,1,1); change_coin held stable while ready=0; coin pulses during CHANGE -> coin_reject.
- Assert reset mid-CHANGE at credit 6 -> next cycle credit 0, change_valid 0, IDLE. vend_req and cancel together at credit 20 -> no ack, full refund 10,10.
